// File: rtl/case_1_acc_12s_16s_sat.sv
// Streaming saturating accumulator for the case_1 kernel: sums NUM_TERMS signed
// products into one registered dot-product result, with valid/ready on both sides.
module case_1_acc_12s_16s_sat #(
  parameter int PROD_WIDTH = 12,
  parameter int ACC_WIDTH  = 16,
  parameter int NUM_TERMS  = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         acc_clr,
  input  logic signed [PROD_WIDTH-1:0] prod_din,
  input  logic                         prod_vld,
  output logic                         prod_rdy,
  output logic signed [ACC_WIDTH-1:0]  sum_dout,
  output logic                         sum_ovf,
  output logic                         sum_vld,
  input  logic                         sum_rdy
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam int CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);

  localparam logic [ACC_WIDTH-1:0] SAT_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sum_dout_q, sum_dout_d;
  logic                 sum_ovf_q, sum_ovf_d;
  logic                 sum_vld_q, sum_vld_d;
  logic                 init_q;

  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   raw_sum;
  logic                 clamp;
  logic [ACC_WIDTH-1:0] nxt;
  logic                 accept;

  // One guard bit above the accumulator exposes overflow as a disagreement
  // between the top two bits of the widened sum.
  always_comb begin
    prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    raw_sum  = {acc_q[ACC_WIDTH-1], acc_q} + prod_ext;
    clamp    = raw_sum[ACC_WIDTH] ^ raw_sum[ACC_WIDTH-1];
    if (clamp) nxt = raw_sum[ACC_WIDTH] ? SAT_NEG : SAT_POS;
    else       nxt = raw_sum[ACC_WIDTH-1:0];
  end

  // init_q keeps the input side closed while reset is held and for the
  // remainder of that cycle, so the first accept is after deassertion.
  assign prod_rdy = init_q & (state_q == ST_ACCUM) & ~acc_clr;
  assign accept   = prod_vld & prod_rdy;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_dout_d = sum_dout_q;
    sum_ovf_d  = sum_ovf_q;
    sum_vld_d  = sum_vld_q;

    case (state_q)
      ST_ACCUM: begin
        if (acc_clr) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (cnt_q == LAST_CNT) begin
            sum_dout_d = nxt;
            sum_ovf_d  = ovf_q | clamp;
            sum_vld_d  = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            state_d    = ST_HOLD;
          end else begin
            acc_d = nxt;
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | clamp;
          end
        end
      end
      ST_HOLD: begin
        // The result stays put until taken; acc_clr has no effect here.
        if (sum_rdy) begin
          sum_vld_d = 1'b0;
          state_d   = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_dout_q <= '0;
      sum_ovf_q  <= 1'b0;
      sum_vld_q  <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sum_dout_q <= sum_dout_d;
      sum_ovf_q  <= sum_ovf_d;
      sum_vld_q  <= sum_vld_d;
      init_q     <= 1'b1;
    end
  end

  assign sum_dout = sum_dout_q;
  assign sum_ovf  = sum_ovf_q;
  assign sum_vld  = sum_vld_q;

endmodule

// File: tb/tb_case_1_acc_12s_16s_sat.sv
// Scoreboard bench: stimulus queues hand-computed group results, per-DUT monitors
// pop and compare on each output handshake. dut1 uses ACC_WIDTH=14 to reach saturation.
module tb_case_1_acc_12s_16s_sat;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic               acc_clr0 = 1'b0, pv0 = 1'b0, sr0 = 1'b1;
  logic signed [11:0] pd0 = '0;
  logic               pr0, so0, sv0;
  logic signed [15:0] sd0;

  logic               acc_clr1 = 1'b0, pv1 = 1'b0, sr1 = 1'b1;
  logic signed [11:0] pd1 = '0;
  logic               pr1, so1, sv1;
  logic signed [13:0] sd1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   w;

  case_1_acc_12s_16s_sat dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .acc_clr(acc_clr0),
    .prod_din(pd0), .prod_vld(pv0), .prod_rdy(pr0),
    .sum_dout(sd0), .sum_ovf(so0), .sum_vld(sv0), .sum_rdy(sr0)
  );

  case_1_acc_12s_16s_sat #(.PROD_WIDTH(12), .ACC_WIDTH(14), .NUM_TERMS(8)) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .acc_clr(acc_clr1),
    .prod_din(pd1), .prod_vld(pv1), .prod_rdy(pr1),
    .sum_dout(sd1), .sum_ovf(so1), .sum_vld(sv1), .sum_rdy(sr1)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One beat: hold prod_vld until the DUT accepts it; returns cycles spent waiting.
  task automatic send(input bit sel, input int v, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    if (sel) begin pv1 = 1'b1; pd1 = 12'(v); end
    else     begin pv0 = 1'b1; pd0 = 12'(v); end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ap_clk);
      if (sel ? pr1 : pr0) got = 1'b1;
      else                 waited++;
    end
    @(posedge ap_clk);
    #1;
    pv0 = 1'b0;
    pv1 = 1'b0;
    check("accept_within_budget", 32'(got), 1);
  endtask

  task automatic send_n(input bit sel, input int v, input int n);
    int wt;
    for (int i = 0; i < n; i++) send(sel, v, wt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && sv0 && sr0) begin
      if (q0.size() == 0) check("dut0_unexpected_result", q0.size(), 1);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0_sum_dout", sd0, e.sum);
        check("dut0_sum_ovf", 32'(so0), 32'(e.ovf));
      end
    end
  end

  always @(negedge ap_clk) begin
    if (!ap_rst && sv1 && sr1) begin
      if (q1.size() == 0) check("dut1_unexpected_result", q1.size(), 1);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1_sum_dout", sd1, e.sum);
        check("dut1_sum_ovf", 32'(so1), 32'(e.ovf));
      end
    end
  end

  initial begin
    // Reset state
    #1 ap_rst = 1'b1;
    #2;
    check("rst_sum_dout", sd0, 0);
    check("rst_sum_vld", 32'(sv0), 0);
    check("rst_sum_ovf", 32'(so0), 0);
    check("rst_prod_rdy", 32'(pr0), 0);
    #19 ap_rst = 1'b0;
    check("rdy_low_before_first_edge", 32'(pr0), 0);
    @(posedge ap_clk);
    #1;
    check("rdy_high_after_release", 32'(pr0), 1);

    // 1. Basic groups, back to back
    q0.push_back('{24, 1'b0});
    send_n(0, 3, 8);
    check("t1_sum_vld_after_8th", 32'(sv0), 1);
    q0.push_back('{24, 1'b0});
    send(0, 3, w);
    check("t1_rdy_low_one_cycle", w, 1);
    send_n(0, 3, 7);
    idle(1);
    check("t1_vld_dropped", 32'(sv0), 0);
    check("t1_dout_kept", sd0, 24);

    // 2. Mixed signs with bubbles
    q0.push_back('{-987, 1'b0});
    send(0, -2048, w); idle(2);
    send(0, 1024, w);  idle(1);
    send(0, -5, w);
    send(0, 7, w);     idle(3);
    send(0, 0, w);
    send(0, -1, w);    idle(1);
    send(0, 100, w);   idle(2);
    send(0, -64, w);
    idle(2);

    // 3. Saturation on the 14-bit instance
    q1.push_back('{8191, 1'b1});
    send_n(1, 2047, 8);
    q1.push_back('{-8, 1'b0});
    send_n(1, -1, 8);
    q1.push_back('{-8192, 1'b1});
    send_n(1, -2048, 8);
    q1.push_back('{2047, 1'b1});
    send_n(1, 2047, 5);
    send_n(1, -2048, 3);
    idle(2);

    // 4. Backpressure
    sr0 = 1'b0;
    q0.push_back('{36, 1'b0});
    for (int i = 1; i <= 8; i++) send(0, i, w);
    pv0 = 1'b1;
    pd0 = 12'sd500;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("t4_vld_held", 32'(sv0), 1);
      check("t4_dout_stable", sd0, 36);
      check("t4_rdy_low", 32'(pr0), 0);
    end
    @(posedge ap_clk);
    #1;
    sr0 = 1'b1;
    pv0 = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("t4_rdy_after_release", 32'(pr0), 1);
    check("t4_vld_after_release", 32'(sv0), 0);
    idle(1);

    // 5. Clear
    send_n(0, 10, 3);
    acc_clr0 = 1'b1;
    pv0 = 1'b1;
    pd0 = 12'sd77;
    @(negedge ap_clk);
    check("t5_rdy_low_during_clr", 32'(pr0), 0);
    @(posedge ap_clk);
    #1;
    acc_clr0 = 1'b0;
    pv0 = 1'b0;
    sr0 = 1'b0;
    q0.push_back('{8, 1'b0});
    send_n(0, 1, 8);
    acc_clr0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge ap_clk);
      check("t5_hold_vld_under_clr", 32'(sv0), 1);
      check("t5_hold_dout_under_clr", sd0, 8);
    end
    @(posedge ap_clk);
    #1;
    acc_clr0 = 1'b0;
    sr0 = 1'b1;
    idle(2);

    // 6. Async reset mid-group
    send_n(0, 5, 4);
    #3 ap_rst = 1'b1;
    #1;
    check("t6_rst_dout0", sd0, 0);
    check("t6_rst_vld0", 32'(sv0), 0);
    check("t6_rst_ovf0", 32'(so0), 0);
    check("t6_rst_rdy0", 32'(pr0), 0);
    check("t6_rst_dout1", sd1, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("t6_rdy_low_in_rst", 32'(pr0), 0);
    #2 ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    check("t6_rdy_after_release", 32'(pr0), 1);
    q0.push_back('{16, 1'b0});
    send_n(0, 2, 8);

    // Drain
    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++)
      @(posedge ap_clk);
    idle(1);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
